// File: rtl/pll_reset_seq.sv
// pll_reset_seq: drives the PLL reset and waits for lock. A lock attempt that
// times out is retried a bounded number of times. Lock must then hold for a
// continuous window before the core reset is released, and the sequence
// restarts by itself if lock is lost while running.
//
// Ports:
//   refclk        - reference clock, the only clock in the block
//   rst           - synchronous, active-high reset
//   pll_locked    - PLL lock indicator, asynchronous to refclk
//   pll_rst       - reset to the PLL, active high
//   sys_reset     - core reset, active high
//   ready         - high only while running with a stable lock
//   fail          - high once the retry budget is exhausted; cleared only by rst
//   retry_cnt     - failed lock attempts since the last entry to RUN
//   lock_loss_cnt - saturating count of lock losses while running
module pll_reset_seq #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 5000000,
    parameter int unsigned STABLE_CYCLES  = 65536,
    parameter int unsigned RETRY_MAX      = 7,
    parameter int unsigned CNT_W          = 24
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_reset,
    output logic       ready,
    output logic       fail,
    output logic [2:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMER_ONE    = CNT_W'(1);
    localparam logic [2:0]       RETRY_LIM    = 3'(RETRY_MAX);

    typedef enum logic [2:0] {
        S_PLLRST   = 3'd0,
        S_WAITLOCK = 3'd1,
        S_STABLE   = 3'd2,
        S_RUN      = 3'd3,
        S_FAIL     = 3'd4
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       timer;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic [2:0]             retry_inc;

    // Synchroniser for the asynchronous lock indicator
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign locked_s  = sync_q[SYNC_STAGES-1];
    assign retry_inc = retry_cnt + 3'd1;

    // Sequencer; every output is set on the edge that changes state
    always_ff @(posedge refclk) begin
        if (rst) begin
            state         <= S_PLLRST;
            timer         <= '0;
            pll_rst       <= 1'b1;
            sys_reset     <= 1'b1;
            ready         <= 1'b0;
            fail          <= 1'b0;
            retry_cnt     <= '0;
            lock_loss_cnt <= '0;
        end else begin
            case (state)
                S_PLLRST: begin
                    if (timer == PLL_RST_LAST) begin
                        state   <= S_WAITLOCK;
                        timer   <= '0;
                        pll_rst <= 1'b0;
                    end else begin
                        timer <= timer + TIMER_ONE;
                    end
                end

                // Lock is checked before the timeout, so a tie goes to lock
                S_WAITLOCK: begin
                    if (locked_s) begin
                        state <= S_STABLE;
                        timer <= '0;
                    end else if (timer == TIMEOUT_LAST) begin
                        retry_cnt <= retry_inc;
                        timer     <= '0;
                        pll_rst   <= 1'b1;
                        if (retry_inc == RETRY_LIM) begin
                            state <= S_FAIL;
                            fail  <= 1'b1;
                        end else begin
                            state <= S_PLLRST;
                        end
                    end else begin
                        timer <= timer + TIMER_ONE;
                    end
                end

                // Any dropout restarts the lock wait without costing a retry
                S_STABLE: begin
                    if (!locked_s) begin
                        state <= S_WAITLOCK;
                        timer <= '0;
                    end else if (timer == STABLE_LAST) begin
                        state     <= S_RUN;
                        timer     <= '0;
                        sys_reset <= 1'b0;
                        ready     <= 1'b1;
                        retry_cnt <= '0;
                    end else begin
                        timer <= timer + TIMER_ONE;
                    end
                end

                S_RUN: begin
                    if (!locked_s) begin
                        state     <= S_PLLRST;
                        timer     <= '0;
                        pll_rst   <= 1'b1;
                        sys_reset <= 1'b1;
                        ready     <= 1'b0;
                        if (lock_loss_cnt != 8'hFF) begin
                            lock_loss_cnt <= lock_loss_cnt + 8'd1;
                        end
                    end
                end

                // Terminal until rst; the lock input is ignored here
                S_FAIL: begin
                    pll_rst   <= 1'b1;
                    sys_reset <= 1'b1;
                    ready     <= 1'b0;
                    fail      <= 1'b1;
                end

                default: begin
                    state     <= S_PLLRST;
                    timer     <= '0;
                    pll_rst   <= 1'b1;
                    sys_reset <= 1'b1;
                    ready     <= 1'b0;
                    fail      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Bench for pll_reset_seq. Stimulus walks through normal lock, lock loss in
// RUN, a STABLE glitch, the timeout/lock tie, exhaustion into FAIL and resets
// mid-sequence. For every output change it expects, it queues the edge number
// and output vector; a monitor pops an entry whenever the outputs change.
module tb_pll_reset_seq;

    logic       refclk;
    logic       rst;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic       fail;
    logic [2:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    typedef struct packed {
        logic       pll_rst;
        logic       sys_reset;
        logic       ready;
        logic       fail;
        logic [2:0] retry_cnt;
        logic [7:0] lock_loss_cnt;
    } out_t;

    typedef struct {
        string name;
        int    cyc;
        out_t  o;
    } ev_t;

    ev_t exp_q[$];
    int  cyc   = 0;
    int  total = 0;
    int  bad   = 0;

    pll_reset_seq #(
        .SYNC_STAGES    (2),
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (100),
        .STABLE_CYCLES  (20),
        .RETRY_MAX      (3),
        .CNT_W          (24)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .pll_rst       (pll_rst),
        .sys_reset     (sys_reset),
        .ready         (ready),
        .fail          (fail),
        .retry_cnt     (retry_cnt),
        .lock_loss_cnt (lock_loss_cnt)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    // Edge n leaves cyc == n
    always @(posedge refclk) cyc <= cyc + 1;

    // Return at the falling edge after rising edge n; inputs set here are sampled at edge n+1
    task automatic goto(input int n);
        while (cyc < n) @(negedge refclk);
    endtask

    task automatic expect_ev(input string name, input int c, input logic pr, input logic sr,
                             input logic rd, input logic fl, input int rc, input int llc);
        ev_t e;
        e.name = name;
        e.cyc  = c;
        e.o    = {pr, sr, rd, fl, 3'(rc), 8'(llc)};
        exp_q.push_back(e);
    endtask

    // Monitor: every change in the output vector consumes one expectation
    initial begin
        out_t prev;
        out_t cur;
        ev_t  e;
        prev = 'x;
        forever begin
            @(posedge refclk);
            #1;
            cur = {pll_rst, sys_reset, ready, fail, retry_cnt, lock_loss_cnt};
            if (cur !== prev) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change: cycle=%0d outputs=%h required=no change", cyc, cur);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.o !== cur) begin
                        bad++;
                        $display("FAIL %s: got cycle=%0d outputs=%h, required cycle=%0d outputs=%h",
                                 e.name, cyc, cur, e.cyc, e.o);
                    end
                end
            end
            prev = cur;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: sim time expired, pending expectations=%0d", exp_q.size());
        $fatal(1, "watchdog");
    end

    // Outputs: pll_rst, sys_reset, ready, fail, retry_cnt, lock_loss_cnt
    initial begin
        rst        = 1'b1;
        pll_locked = 1'b0;
        expect_ev("reset_values", 1, 1, 1, 0, 0, 0, 0);

        // Normal lock: pll_rst high 4 cycles, RUN 23 edges counting the sampling edge 16
        goto(2);  rst = 1'b0;
        expect_ev("pllrst_end", 6, 0, 1, 0, 0, 0, 0);
        goto(15); pll_locked = 1'b1;
        expect_ev("normal_run", 38, 0, 0, 1, 0, 0, 0);

        // Lock loss in RUN: low sampled at 46, reaction at 48
        goto(45); pll_locked = 1'b0;
        expect_ev("lock_loss", 48, 1, 1, 0, 0, 0, 1);
        expect_ev("loss_pllrst_end", 52, 0, 1, 0, 0, 0, 1);
        goto(55); pll_locked = 1'b1;
        expect_ev("relock_run", 78, 0, 0, 1, 0, 0, 1);

        // Reset from RUN clears lock_loss_cnt
        goto(80); rst = 1'b1; pll_locked = 1'b0;
        expect_ev("reset_from_run", 81, 1, 1, 0, 0, 0, 0);
        goto(81); rst = 1'b0;
        expect_ev("pllrst_end_b", 85, 0, 1, 0, 0, 0, 0);

        // STABLE glitch: locked_s low only at the edge where the stable timer is 15
        goto(89);  pll_locked = 1'b1;
        goto(105); pll_locked = 1'b0;
        goto(106); pll_locked = 1'b1;
        expect_ev("glitch_full_window", 129, 0, 0, 1, 0, 0, 0);

        // Reset during STABLE
        goto(132); rst = 1'b1; pll_locked = 1'b0;
        expect_ev("reset_from_run_c", 133, 1, 1, 0, 0, 0, 0);
        goto(133); rst = 1'b0;
        expect_ev("pllrst_end_c", 137, 0, 1, 0, 0, 0, 0);
        goto(139); pll_locked = 1'b1;
        goto(150); rst = 1'b1; pll_locked = 1'b0;
        expect_ev("reset_in_stable", 151, 1, 1, 0, 0, 0, 0);
        goto(151); rst = 1'b0;
        expect_ev("pllrst_end_d", 155, 0, 1, 0, 0, 0, 0);

        // Timeout tie: locked_s first seen at edge 255 where the wait timer is 99
        goto(252); pll_locked = 1'b1;
        expect_ev("tie_lock_wins", 275, 0, 0, 1, 0, 0, 0);

        // No lock: three pulses 104 apart, then FAIL
        goto(280); rst = 1'b1; pll_locked = 1'b0;
        expect_ev("reset_before_nolock", 281, 1, 1, 0, 0, 0, 0);
        goto(281); rst = 1'b0;
        expect_ev("nolock_pulse1_end", 285, 0, 1, 0, 0, 0, 0);
        expect_ev("timeout1", 385, 1, 1, 0, 0, 1, 0);
        expect_ev("nolock_pulse2_end", 389, 0, 1, 0, 0, 1, 0);
        expect_ev("timeout2", 489, 1, 1, 0, 0, 2, 0);
        expect_ev("nolock_pulse3_end", 493, 0, 1, 0, 0, 2, 0);
        expect_ev("enter_fail", 593, 1, 1, 0, 1, 3, 0);

        // Lock in FAIL is ignored; only rst leaves
        goto(600); pll_locked = 1'b1;
        goto(650); rst = 1'b1;
        expect_ev("reset_in_fail", 651, 1, 1, 0, 0, 0, 0);
        goto(651); rst = 1'b0;
        expect_ev("pllrst_end_e", 655, 0, 1, 0, 0, 0, 0);
        expect_ev("run_after_fail", 676, 0, 0, 1, 0, 0, 0);

        goto(690);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_events: pending=%0d required=0 (next %s at cycle %0d)",
                     exp_q.size(), exp_q[0].name, exp_q[0].cyc);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_reset_seq.md
Name: pll_reset_seq

Overview:
- Sits directly beside the system PLL and runs on the same 50 MHz reference clock that feeds it.
- Drives the PLL's `rst` input and consumes the PLL's `locked` output.
- Pulses the PLL reset and waits for lock, with a timeout and a bounded number of retries.
- Requires a continuous stable-lock window, then releases the core system reset.
- Re-sequences automatically when lock is lost during operation.

Parameters:
- SYNC_STAGES, 2: flip-flop stages synchronising `pll_locked` into `refclk`; legal range 2..4.
- PLL_RST_CYCLES, 16: number of cycles `pll_rst` is held high per attempt; must be ≥1.
- LOCK_TIMEOUT, 5000000: cycles to wait for lock per attempt (100 ms at 50 MHz).
- STABLE_CYCLES, 65536: consecutive synchronised-lock cycles required before `sys_reset` is released.
- RETRY_MAX, 7: failed attempts allowed before entering FAIL; range 1..7.
- CNT_W, 24: width of the shared timer; must hold max(LOCK_TIMEOUT, STABLE_CYCLES, PLL_RST_CYCLES).

Ports:
- refclk, input, 1: reference clock; the only clock in the block.
- rst, input, 1: synchronous, active-high reset.
- pll_locked, input, 1: PLL lock indicator; asynchronous to `refclk`.
- pll_rst, output, 1: reset to the PLL, active high.
- sys_reset, output, 1: core reset, active high.
- ready, output, 1: high only in RUN.
- fail, output, 1: high only in FAIL.
- retry_cnt, output, 3: failed attempts since the last entry to RUN.
- lock_loss_cnt, output, 8: saturating count of RUN→PLLRST transitions.

Behaviour:
- Interface: one clock, `refclk`. Reset `rst` is synchronous and active-high; it is sampled on the rising edge of `refclk`.
- All outputs are registered.
- Reset values:
  - state = PLLRST, timer = 0, sync chain = 0.
  - pll_rst = 1, sys_reset = 1, ready = 0, fail = 0.
  - retry_cnt = 0, lock_loss_cnt = 0.
- `rst` asserted in any state, including mid-sequence, returns everything to the reset values on the next edge.
- `locked_s` is `pll_locked` after SYNC_STAGES flops. All decisions below use only `locked_s`.
- PLLRST:
  - pll_rst = 1, sys_reset = 1.
  - Timer counts 0..PLL_RST_CYCLES-1, so pll_rst is high for exactly PLL_RST_CYCLES cycles.
  - Then → WAITLOCK with timer = 0.
- WAITLOCK:
  - pll_rst = 0, sys_reset = 1.
  - If locked_s = 1 → STABLE with timer = 0.
  - Else if timer = LOCK_TIMEOUT-1: retry_cnt increments. If the new value = RETRY_MAX → FAIL, otherwise → PLLRST.
  - Else timer increments.
  - If locked_s rises on the same cycle as the timeout, lock wins and no retry is counted.
- STABLE:
  - pll_rst = 0, sys_reset = 1.
  - If locked_s = 0 → WAITLOCK with timer = 0. The timeout window restarts and retry_cnt is unchanged.
  - If locked_s = 1 and timer = STABLE_CYCLES-1 → RUN.
  - Otherwise timer increments.
- RUN:
  - pll_rst = 0, sys_reset = 0, ready = 1.
  - retry_cnt is cleared on entry.
  - If locked_s = 0 → PLLRST with timer = 0; lock_loss_cnt increments, saturating at 255.
  - On that same transition edge, sys_reset and pll_rst both become 1 and ready becomes 0.
- FAIL:
  - pll_rst = 1, sys_reset = 1, fail = 1.
  - pll_locked is ignored; only `rst` exits FAIL.
- Latency: once lock is held continuously, sys_reset falls SYNC_STAGES + 1 + STABLE_CYCLES cycles after the first `refclk` edge that samples pll_locked = 1 (while in WAITLOCK).
- Outputs never glitch: each is a direct register.
- ready = ~sys_reset holds in every state except FAIL (in FAIL, ready = 0 and sys_reset = 1).

Test Plan:
Bench parameters: SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=20, RETRY_MAX=3.

1. Normal lock: rst for 2 cycles, pll_locked rises 10 cycles after pll_rst falls and stays high → pll_rst high exactly 4 cycles; sys_reset falls and ready rises 23 cycles after lock is first sampled; retry_cnt = 0.
2. No lock: pll_locked held at 0 → three pll_rst pulses of 4 cycles each, spaced 104 cycles apart; then fail = 1, retry_cnt = 3, pll_rst stays 1; later raising pll_locked has no effect until rst.
3. Glitch in STABLE: locked_s drops for 1 cycle at stable timer = 15 → returns to WAITLOCK; on relock a full 20-cycle window is required; sys_reset stays 1 throughout; retry_cnt = 0.
4. Lock loss in RUN: drop pll_locked → exactly SYNC_STAGES+1 edges later sys_reset = 1, pll_rst = 1, ready = 0, lock_loss_cnt = 1; relock returns to RUN with lock_loss_cnt still 1.
5. Timeout tie: locked_s rises on the cycle where the WAITLOCK timer = 99 → enters STABLE, retry_cnt unchanged, no pll_rst pulse.
6. Reset mid-operation: assert rst during STABLE and during FAIL → on the next edge every output and counter equals its reset value (pll_rst = 1, sys_reset = 1, counts = 0).
